mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: nRst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  request pulse, sampled in IDLE only.
REQ-004 SHALL have ports: cuOP  in  6  control-unit op; LB=10, LH=11, LW=12, LBU=13, LHU=14, SB=15, SH=16, SW=17; all others are non-memory ops.
REQ-005 SHALL have ports: addr  in  32  byte address (ALU result); storeData  in  32  rs2 value.
REQ-006 SHALL have ports: busy  out  1  high whenever state is not IDLE; done  out  1  one-cycle completion pulse; error  out  1  one-cycle misalignment pulse.
REQ-007 SHALL have ports: memload  out  32  lane-aligned load word, low-justified and zero-filled, for write-back sign/zero extension.
REQ-008 SHALL have ports: bus_req, bus_we  out  1; bus_addr  out  32  word-aligned ({addr[31:2],2'b00}); bus_wdata  out  32; bus_be  out  4; bus_rdata  in  32; bus_ack  in  1.

Function
REQ-009 SHALL implement states IDLE, REQ, DONE, ERR, with all outputs registered.
REQ-010 In IDLE, start=1 with a memory cuOP SHALL latch cuOP/addr/storeData and go to REQ; start with a non-memory op SHALL be ignored.
REQ-011 In REQ, bus_req SHALL be 1 and bus_we/bus_addr/bus_wdata/bus_be SHALL be held stable until bus_ack is sampled 1.
REQ-012 On bus_ack=1 in REQ, the unit SHALL go to DONE and deassert bus_req the next cycle; with ack at cycle M, done=1 in cycle M+1 only, then IDLE.
REQ-013 Minimum latency SHALL be start at cycle N -> bus_req at N+1 -> done at N+2, given ack at N+1.
REQ-014 bus_ack outside REQ and start outside IDLE SHALL be ignored.
REQ-015 SB SHALL drive bus_be=4'b0001<<addr[1:0], bus_wdata={4{storeData[7:0]}}; SH SHALL drive bus_be=4'b0011<<{addr[1],1'b0}, bus_wdata={2{storeData[15:0]}}; SW SHALL drive bus_be=4'b1111, bus_wdata=storeData; bus_we=1 for stores.
REQ-016 Loads SHALL drive bus_we=0, bus_be per the same size rule, and bus_wdata=0.
REQ-017 On ack for a load, memload SHALL capture bus_rdata>>(8*addr[1:0]) for byte ops and bus_rdata>>(16*addr[1]) for halfword ops, masked to 8/16 bits, or bus_rdata for LW.
REQ-018 memload SHALL hold its value until the next load completes; stores SHALL NOT modify it.
REQ-019 done and error SHALL never be high together.

Reset
REQ-020 nRst=0 SHALL immediately force state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, busy=0, done=0, error=0, memload=0, including mid-transaction; any pending ack SHALL be dropped.
REQ-021 After reset release, the first start SHALL be accepted on the first clock edge.

Configuration
REQ-022 With MISALIGN_CHECK_EN defined, LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL skip REQ and go to ERR, with no bus_req; error=1 for one cycle, then IDLE, and memload SHALL be unchanged.
REQ-023 Without MISALIGN_CHECK_EN, error SHALL be tied 0, halfword ops SHALL ignore addr[0], and word ops SHALL ignore addr[1:0].

Verification
REQ-024 SB, addr=0x103, storeData=0x000000A5, ack after 2 cycles -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x100, done 1 cycle after ack.
REQ-025 LB, addr=0x202, bus_rdata=0x11AA2233, ack immediate -> memload=0x000000AA at done, busy high exactly 2 cycles.
REQ-026 LHU, addr=0x302, bus_rdata=0xBEEF1234 -> memload=0x0000BEEF; subsequent SW leaves memload=0x0000BEEF.
REQ-027 Start LW, then assert nRst=0 while in REQ -> bus_req drops asynchronously, no done; a later LW addr=0x0, rdata=0xDEADBEEF -> memload=0xDEADBEEF.
REQ-028 With MISALIGN_CHECK_EN, SW addr=0x102 -> no bus_req, error pulse at N+1, done stays 0; without the macro -> bus_be=1111 and bus_addr=0x100.
REQ-029 start with cuOP=ADD (28), and bus_ack pulsed while in IDLE -> no state change, busy=0, done=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: one memory op at a time on a req/ack bus, with byte lane steering and load data alignment.
// Optional MISALIGN_CHECK_EN: misaligned halfword/word ops pulse error instead of reaching the bus.
module mem_access_unit (
    input  logic        clk,
    input  logic        nRst,
    input  logic        start,
    input  logic [5:0]  cuOP,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] memload,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [5:0] OP_LB  = 6'd10;
    localparam logic [5:0] OP_LH  = 6'd11;
    localparam logic [5:0] OP_LBU = 6'd13;
    localparam logic [5:0] OP_LHU = 6'd14;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd17;

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t      state, state_next;
    logic        is_mem, is_store, is_byte, is_half, misaligned;
    logic        accept, complete;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [5:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] byte_shift, half_shift, load_word;

    always_comb begin
        is_mem   = (cuOP >= OP_LB) && (cuOP <= OP_SW);
        is_store = (cuOP >= OP_SB) && (cuOP <= OP_SW);
        is_byte  = (cuOP == OP_LB) || (cuOP == OP_LBU) || (cuOP == OP_SB);
        is_half  = (cuOP == OP_LH) || (cuOP == OP_LHU) || (cuOP == OP_SH);
        if (is_byte) begin
            be_new    = 4'b0001 << addr[1:0];
            wdata_new = {4{storeData[7:0]}};
        end else if (is_half) begin
            be_new    = 4'b0011 << {addr[1], 1'b0};
            wdata_new = {2{storeData[15:0]}};
        end else begin
            be_new    = 4'b1111;
            wdata_new = storeData;
        end
        if (!is_store) begin
            wdata_new = '0;
        end
`ifdef MISALIGN_CHECK_EN
        misaligned = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_mem) begin
                    if (misaligned) begin
                        state_next = ERR;
                    end else begin
                        state_next = REQ;
                        accept     = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_next = DONE;
                    complete   = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read data arrives word-aligned; shift the addressed lane down to bit 0
    always_comb begin
        byte_shift = bus_rdata >> {lane_q, 3'b000};
        half_shift = bus_rdata >> {lane_q[1], 4'b0000};
        case (op_q)
            OP_LB, OP_LBU: load_word = byte_shift & 32'h0000_00FF;
            OP_LH, OP_LHU: load_word = half_shift & 32'h0000_FFFF;
            default:       load_word = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            memload   <= '0;
            op_q      <= '0;
            lane_q    <= '0;
        end else begin
            busy    <= (state_next != IDLE);
            done    <= (state_next == DONE);
            error   <= (state_next == ERR);
            bus_req <= (state_next == REQ);
            if (accept) begin
                op_q      <= cuOP;
                lane_q    <= addr[1:0];
                bus_we    <= is_store;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_wdata <= wdata_new;
                bus_be    <= be_new;
            end
            if (complete && (op_q < OP_SB)) begin
                memload <= load_word;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table of bus transactions plus reset/idle/misalign sequences.
module tb_mem_access_unit;

    localparam logic [5:0] OP_LB  = 6'd10;
    localparam logic [5:0] OP_LH  = 6'd11;
    localparam logic [5:0] OP_LW  = 6'd12;
    localparam logic [5:0] OP_LBU = 6'd13;
    localparam logic [5:0] OP_LHU = 6'd14;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd17;
    localparam logic [5:0] OP_ADD = 6'd28;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vec_t;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  cuOP = OP_ADD;
    logic [31:0] addr = '0;
    logic [31:0] storeData = '0;
    logic        busy, done, error;
    logic [31:0] memload;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[9];

    mem_access_unit dut (
        .clk(clk), .nRst(nRst), .start(start), .cuOP(cuOP), .addr(addr),
        .storeData(storeData), .busy(busy), .done(done), .error(error),
        .memload(memload), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one transaction, checks the bus phase, acks after v.delay wait cycles, then checks completion
    task automatic applyStimulus(input vec_t v);
        int waited;
        logic [31:0] exp_load;
        @(negedge clk);
        start = 1'b1; cuOP = v.op; addr = v.addr; storeData = v.sdata;
        exp_q.push_back(v.exp_load);
        @(negedge clk);
        start = 1'b0; cuOP = OP_ADD; addr = $urandom; storeData = $urandom;
        check("req_asserted", bus_req, 1'b1);
        check("busy_in_req", busy, 1'b1);
        check("bus_addr", bus_addr, v.exp_addr);
        check("bus_be", bus_be, v.exp_be);
        check("bus_we", bus_we, v.exp_we);
        check("bus_wdata", bus_wdata, v.exp_wdata);
        for (int i = 0; i < v.delay; i++) begin
            start = 1'b1; cuOP = OP_LW;
            @(negedge clk);
            check("req_held", bus_req, 1'b1);
            check("be_held", bus_be, v.exp_be);
            check("wdata_held", bus_wdata, v.exp_wdata);
            check("no_early_done", done, 1'b0);
        end
        start = 1'b0; cuOP = OP_ADD;
        bus_ack = 1'b1; bus_rdata = v.rdata;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = $urandom;
        waited = 0;
        while (!done && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check("done_latency", waited, 0);
        check("req_dropped", bus_req, 1'b0);
        check("busy_in_done", busy, 1'b1);
        check("no_error", error, 1'b0);
        checkOutput();
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("busy_idle", busy, 1'b0);
    endtask

    task automatic checkOutput();
        logic [31:0] exp_load;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp_load = exp_q.pop_front();
            check("memload", memload, exp_load);
        end
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{OP_SB,  32'h103, 32'h0000_00A5, 32'h0,          2, 32'h100, 4'b1000, 1'b1, 32'hA5A5_A5A5, 32'h0};
        vecs[1] = '{OP_LB,  32'h202, 32'h0,          32'h11AA_2233, 0, 32'h200, 4'b0100, 1'b0, 32'h0,          32'h0000_00AA};
        vecs[2] = '{OP_LHU, 32'h302, 32'h0,          32'hBEEF_1234, 1, 32'h300, 4'b1100, 1'b0, 32'h0,          32'h0000_BEEF};
        vecs[3] = '{OP_SW,  32'h400, 32'h1234_5678, 32'hFFFF_FFFF, 0, 32'h400, 4'b1111, 1'b1, 32'h1234_5678, 32'h0000_BEEF};
        vecs[4] = '{OP_LW,  32'h010, 32'h0,          32'hCAFE_F00D, 3, 32'h010, 4'b1111, 1'b0, 32'h0,          32'hCAFE_F00D};
        vecs[5] = '{OP_SH,  32'h206, 32'hAAAA_5566, 32'h0,          1, 32'h204, 4'b1100, 1'b1, 32'h5566_5566, 32'hCAFE_F00D};
        vecs[6] = '{OP_LH,  32'h008, 32'h0,          32'h8001_7FFE, 0, 32'h008, 4'b0011, 1'b0, 32'h0,          32'h0000_7FFE};
        vecs[7] = '{OP_LBU, 32'h001, 32'h0,          32'h0000_C300, 2, 32'h000, 4'b0010, 1'b0, 32'h0,          32'h0000_00C3};
        vecs[8] = '{OP_SB,  32'h000, 32'hFFFF_FF3C, 32'h0,          0, 32'h000, 4'b0001, 1'b1, 32'h3C3C_3C3C, 32'h0000_00C3};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_req", bus_req, 1'b0);
        check("rst_be", bus_be, 4'b0000);
        check("rst_memload", memload, 32'h0);
        nRst = 1'b1;

        // Non-memory op and stray ack in IDLE
        @(negedge clk);
        start = 1'b1; cuOP = OP_ADD; bus_ack = 1'b1;
        @(negedge clk);
        start = 1'b0; bus_ack = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("idle_req", bus_req, 1'b0);
        check("idle_done", done, 1'b0);
        @(negedge clk);
        check("idle_busy2", busy, 1'b0);
        check("idle_done2", done, 1'b0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end

        // Asynchronous reset in the middle of a load
        @(negedge clk);
        start = 1'b1; cuOP = OP_LW; addr = 32'h0;
        @(negedge clk);
        start = 1'b0; cuOP = OP_ADD;
        check("abort_req_before", bus_req, 1'b1);
        #2 nRst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        #1;
        check("abort_req_async", bus_req, 1'b0);
        check("abort_busy_async", busy, 1'b0);
        check("abort_memload", memload, 32'h0);
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("abort_no_done", done, 1'b0);
        check("abort_idle", busy, 1'b0);
        @(negedge clk);
        check("abort_no_done2", done, 1'b0);

        v = '{OP_LW, 32'h0, 32'h0, 32'hDEAD_BEEF, 1, 32'h0, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF};
        applyStimulus(v);

`ifdef MISALIGN_CHECK_EN
        @(negedge clk);
        start = 1'b1; cuOP = OP_SW; addr = 32'h102; storeData = 32'h0102_0304;
        @(negedge clk);
        start = 1'b0; cuOP = OP_ADD;
        check("mis_error", error, 1'b1);
        check("mis_req", bus_req, 1'b0);
        check("mis_done", done, 1'b0);
        @(negedge clk);
        check("mis_error_pulse", error, 1'b0);
        check("mis_idle", busy, 1'b0);
        check("mis_req2", bus_req, 1'b0);
        check("mis_memload", memload, 32'hDEAD_BEEF);
`else
        v = '{OP_SW, 32'h102, 32'h0102_0304, 32'h0, 0, 32'h100, 4'b1111, 1'b1, 32'h0102_0304, 32'hDEAD_BEEF};
        applyStimulus(v);
        check("no_mis_error", error, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
